mem_read_streamer: RTL and testbench
====================================

# mem_read_streamer

Read-side sequencer that sits directly downstream of the 16×32 scratchpad memory in the TPU datapath. On a `start` command it issues a burst of consecutive synchronous reads (with address wrap-around), absorbs the memory's 1-cycle registered read latency in a 2-entry buffer, and presents the words on a valid/ready stream to the consumer, such as a systolic-array row feeder. It supports full throughput of 1 word/cycle and arbitrary consumer backpressure without losing or duplicating words.

## Interface
- `ADDR_WIDTH`, 4: memory address width; memory depth is 2^ADDR_WIDTH = 16.
- `DATA_WIDTH`, 32: word width.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a burst. Sampled only in IDLE; ignored otherwise.
- `base_addr`  in  ADDR_WIDTH: first address of the burst. Latched on an accepted start.
- `length`  in  ADDR_WIDTH+1: number of words, 0..16. Latched on an accepted start.
- `busy`  out  1: high in ISSUE and DRAIN.
- `done`  out  1: one-cycle pulse when the burst completes.
- `mem_addr`  out  ADDR_WIDTH: read address to the memory.
- `mem_read_enable`  out  1: read strobe to the memory.
- `mem_data_out`  in  DATA_WIDTH: memory registered read data. Valid in the cycle after the strobe.
- `out_valid`  out  1: head of the buffer is valid.
- `out_data`  out  DATA_WIDTH: head word.
- `out_ready`  in  1: consumer accept. A handshake occurs when `out_valid & out_ready`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, with `start`=1:
  - Latch `rd_addr`=`base_addr`, `issue_left`=`length`, `out_left`=`length`.
  - If `length`≠0, go to ISSUE; otherwise go to DONE.
- ISSUE issues a read when all of the following hold:
  - `issue_left`≠0
  - `count + pending − pop < 2`, where `count` is buffer occupancy (0..2), `pending` is the in-flight read flag, and `pop` is the output handshake this cycle.
- On a read:
  - Drive `mem_read_enable`=1 and `mem_addr`=`rd_addr`.
  - `rd_addr` ← `rd_addr`+1, modulo 16 (15 wraps to 0).
  - `issue_left` ← `issue_left`−1.
  - `pending` ← 1 for the next cycle.
- `pending`=1 pushes `mem_data_out` into the buffer at the end of that cycle. `mem_data_out` is never captured in any other cycle.
- The buffer is a 2-entry FIFO, in order. Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule; this is asserted in simulation.
- Go to DRAIN when `issue_left` reaches 0.
- DRAIN: on each handshake, `out_left` ← `out_left`−1. When the final handshake occurs (`out_left`=1 and pop), go to DONE.
- DONE lasts exactly 1 cycle: `done`=1, `busy`=0. It always returns to IDLE. `start` is ignored in DONE.
- `mem_read_enable` is 0 in every state other than ISSUE.
- `out_data` holds its value while `out_valid & !out_ready`.
- Reset, including mid-burst:
  - State ← IDLE; counters, `pending` and `count` ← 0.
  - Any in-flight read is discarded.
  - Output values after reset: `busy`=0, `done`=0, `out_valid`=0, `mem_read_enable`=0, `mem_addr`=0, `out_data`=0.

## Timing
- `start` sampled at edge E. Then:
  - First `mem_read_enable` in cycle E+1.
  - Data present on `mem_data_out` in E+2, pushed at the end of E+2.
  - `out_valid`=1 in E+3.
- With `out_ready` held at 1, the burst streams 1 word/cycle: words in cycles E+3 .. E+2+N, `done` in E+3+N.
- `length`=0: `done` in E+1. No reads and no `out_valid`.
- A new `start` is accepted 1 cycle after `done`, in the IDLE cycle.
- `done` and `out_valid` are never high in the same cycle.

## Test plan
- **Basic burst.** Memory holds word i = 0x100+i. Start with `base_addr`=2, `length`=4, `out_ready`=1.
  - Outputs 0x102..0x105 in 4 consecutive cycles, starting 3 cycles after start.
  - `done` 1 cycle after the last word; exactly 4 read strobes.
- **Wrap-around.** `base_addr`=14, `length`=4.
  - `mem_addr` sequence 14, 15, 0, 1; data 0x10E, 0x10F, 0x100, 0x101.
- **Backpressure.** `length`=16, `out_ready` toggles 1-0-0-1 pseudo-randomly.
  - All 16 words in order, none dropped or duplicated; `out_data` stable while stalled.
  - Never more than 2 buffered plus in-flight reads.
- **Zero and full length.**
  - `length`=0: `done` the next cycle with no strobes.
  - `length`=16 with `out_ready`=1: exactly 16 words and `done` at E+19.
- **Ignored start.** Pulse `start` mid-burst and in the DONE cycle.
  - The burst is unaffected; no second burst begins.
- **Reset mid-burst.** Assert `rst` 1 cycle after the 2nd read strobe.
  - Next cycle: `busy`=0, `out_valid`=0, `mem_read_enable`=0.
  - A subsequent start with `base_addr`=5, `length`=2 yields only 0x105 and 0x106.

Source files
------------

// File: rtl/mem_read_streamer.sv
// Read sequencer for the scratchpad: issues a wrapping burst of synchronous reads,
// absorbs the one-cycle read latency in a 2-entry FIFO and streams words out on valid/ready.
module mem_read_streamer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int unsigned LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LW-1:0]         issue_left, out_left;
  logic                  pending;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;
  logic                  pop, push, rd_fire;
  logic [2:0]            occ_after_pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = pending;
  assign mem_addr  = rd_addr;
  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == DONE);

  always_comb begin
    state_next      = state;
    rd_fire         = 1'b0;
    mem_read_enable = 1'b0;
    // Occupancy the buffer will have once this cycle's pop leaves and the in-flight read lands.
    occ_after_pop   = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    case (state)
      IDLE: begin
        if (start) state_next = (length != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        if ((issue_left != '0) && (occ_after_pop < 3'd2)) begin
          rd_fire         = 1'b1;
          mem_read_enable = 1'b1;
          if (issue_left == LW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_left == LW'(1))) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_left <= '0;
      out_left   <= '0;
      pending    <= 1'b0;
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      state   <= state_next;
      pending <= rd_fire;
      if ((state == IDLE) && start) begin
        rd_addr    <= base_addr;
        issue_left <= length;
        out_left   <= length;
      end
      if (rd_fire) begin
        rd_addr    <= rd_addr + ADDR_WIDTH'(1);
        issue_left <= issue_left - LW'(1);
      end
      // Handshakes already occur while still issuing, so out_left tracks every pop.
      if (pop) begin
        out_left <= out_left - LW'(1);
        rd_ptr   <= ~rd_ptr;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= mem_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      assert (!(push && !pop && (count == 2'd2)));
    end
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench for mem_read_streamer: behavioural 16x32 registered-read memory,
// negedge monitor, immediate-assertion checks against hand-computed expectations.
module tb_mem_read_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  length = '0;
  logic        busy, done, mem_read_enable, out_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data_out = '0;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;

  mem_read_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
  always @(posedge clk) if (mem_read_enable) mem_data_out <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0;
  int total = 0;

  logic [31:0] got [$];
  logic [3:0]  strobe_addrs [$];
  int strobes, hs, first_hs, last_hs, max_out, stall_err, stall_cnt, overlap_err;
  bit stall_prev;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read_enable) begin
        strobe_addrs.push_back(mem_addr);
        strobes++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (got.size() == 1) first_hs = cyc;
        last_hs = cyc;
        hs++;
      end
      if (stall_prev) begin
        stall_cnt++;
        if (!out_valid || (out_data !== stall_data)) stall_err++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (strobes - hs > max_out) max_out = strobes - hs;
      if (done && out_valid) overlap_err++;
    end
  end

  bit        bp_en = 1'b0;
  int        bp_i = 0;
  logic [15:0] bp_pat = 16'b1001_0110_1100_1011;
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_ready = bp_pat[bp_i];
      bp_i = (bp_i + 1) % 16;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] qget(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    strobe_addrs.delete();
    strobes = 0; hs = 0; first_hs = -1; last_hs = -1; max_out = 0;
    stall_err = 0; stall_cnt = 0; stall_prev = 1'b0;
  endtask

  // Starts a burst; e is the cycle in which start is sampled.
  task automatic kick(input logic [3:0] b, input logic [4:0] n, output int e);
    clear_mon();
    base_addr = b;
    length = n;
    start = 1'b1;
    e = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pulse_start, output int dc);
    dc = -1000;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        check("done_busy_low", 32'(busy), 32'd0);
        if (pulse_start) start = 1'b1;
        break;
      end
    end
    step();
    start = 1'b0;
  endtask

  int e, dc;

  initial begin
    clear_mon();
    overlap_err = 0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rden", 32'(mem_read_enable), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", out_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic burst
    kick(4'd2, 5'd4, e);
    wait_done(40, 1'b0, dc);
    check("basic_strobes", 32'(strobes), 32'd4);
    check("basic_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("basic_data", qget(i), 32'h102 + 32'(i));
    check("basic_first_lat", 32'(first_hs - e), 32'd3);
    check("basic_consecutive", 32'(last_hs - first_hs), 32'd3);
    check("basic_done_lat", 32'(dc - e), 32'd7);

    // Wrap-around
    kick(4'd14, 5'd4, e);
    wait_done(40, 1'b0, dc);
    check("wrap_strobes", 32'(strobes), 32'd4);
    if (strobe_addrs.size() == 4) begin
      check("wrap_addr0", 32'(strobe_addrs[0]), 32'd14);
      check("wrap_addr1", 32'(strobe_addrs[1]), 32'd15);
      check("wrap_addr2", 32'(strobe_addrs[2]), 32'd0);
      check("wrap_addr3", 32'(strobe_addrs[3]), 32'd1);
    end
    check("wrap_d0", qget(0), 32'h10E);
    check("wrap_d1", qget(1), 32'h10F);
    check("wrap_d2", qget(2), 32'h100);
    check("wrap_d3", qget(3), 32'h101);

    // Backpressure
    bp_i = 0;
    bp_en = 1'b1;
    kick(4'd0, 5'd16, e);
    wait_done(300, 1'b0, dc);
    bp_en = 1'b0;
    out_ready = 1'b1;
    check("bp_words", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("bp_data", qget(i), 32'h100 + 32'(i));
    check("bp_strobes", 32'(strobes), 32'd16);
    check("bp_stall_stable", 32'(stall_err), 32'd0);
    check("bp_stalls_seen", 32'(stall_cnt > 0), 32'd1);
    check("bp_outstanding_le2", 32'(max_out <= 2), 32'd1);
    step();

    // Zero length
    kick(4'd3, 5'd0, e);
    wait_done(5, 1'b0, dc);
    check("zero_done_lat", 32'(dc - e), 32'd1);
    check("zero_strobes", 32'(strobes), 32'd0);
    check("zero_words", 32'(hs), 32'd0);

    // Full length
    kick(4'd7, 5'd16, e);
    wait_done(40, 1'b0, dc);
    check("full_words", 32'(got.size()), 32'd16);
    check("full_strobes", 32'(strobes), 32'd16);
    check("full_first", qget(0), 32'h107);
    check("full_last", qget(15), 32'h106);
    check("full_done_lat", 32'(dc - e), 32'd19);

    // Ignored start mid-burst and in the DONE cycle
    kick(4'd1, 5'd6, e);
    step();
    step();
    base_addr = 4'd9;
    length = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, 1'b1, dc);
    repeat (4) step();
    @(negedge clk);
    check("ign_busy_after", 32'(busy), 32'd0);
    check("ign_strobes", 32'(strobes), 32'd6);
    check("ign_words", 32'(got.size()), 32'd6);
    check("ign_last", qget(5), 32'h106);
    check("ign_done_lat", 32'(dc - e), 32'd9);
    step();

    // Reset mid-burst
    kick(4'd0, 5'd8, e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (strobes >= 2) break;
    end
    check("rstmid_two_strobes", 32'(strobes >= 2), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_rden", 32'(mem_read_enable), 32'd0);
    check("rstmid_data", out_data, 32'd0);
    step();
    kick(4'd5, 5'd2, e);
    wait_done(40, 1'b0, dc);
    repeat (3) step();
    check("post_rst_words", 32'(got.size()), 32'd2);
    check("post_rst_d0", qget(0), 32'h105);
    check("post_rst_d1", qget(1), 32'h106);
    check("post_rst_strobes", 32'(strobes), 32'd2);
    check("done_valid_overlap", 32'(overlap_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
